// File: rtl/mcp3202_spi_responder.sv
// mcp3202_spi_responder
//   Emulates an MCP3202 2-channel 12-bit ADC on the responder side of an SPI
//   mode (0,0) link. It lets the audio ADC master run against two parallel
//   sample inputs instead of the physical converter. SCK, CS and MOSI are
//   oversampled in the clk domain, so no logic is clocked by SCK. clk must run
//   at least 8x faster than SCK.
//
//   Build option: define MCP3202_LSBF_EN to enable the LSB-first tail. When it
//   is enabled, a frame with MSBF=0 repeats B1..B11 after B0. Without it, the
//   MSBF bit is ignored and only zeros follow B0.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   adc_clk/cs/mosi       SPI SCK, chip select (active low), master data (async)
//   adc_miso, miso_oe     responder data and its drive enable (0 = tri-state)
//   sample_ch0/ch1        unsigned channel values converted by each frame
//   conv_done, conv_code  1-clk pulse after B0 is driven, and the code sent
//   cfg_sgl, cfg_odd      SGL/DIFF and ODD/SIGN bits of the current/last frame

module mcp3202_spi_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W      = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              adc_clk,
    input  logic              adc_cs,
    input  logic              adc_mosi,
    output logic              adc_miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] sample_ch0,
    input  logic [DATA_W-1:0] sample_ch1,
    output logic              conv_done,
    output logic [DATA_W-1:0] conv_code,
    output logic              cfg_sgl,
    output logic              cfg_odd
);

    typedef enum logic [2:0] {
        IDLE, START, CFG, NUL, MSB, TAIL
`ifdef MCP3202_LSBF_EN
        , LSB
`endif
    } state_t;

    // Synchronisers. The CS chain resets to 0. A CS that is held low while
    // reset is released therefore produces no fall, and the master has to
    // deassert CS and assert it again before a frame starts.
    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_h, cs_h;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge and the order of statements is
    // irrelevant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            cs_sync   <= '0;
            mosi_sync <= '0;
            sck_h     <= 1'b0;
            cs_h      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], adc_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], adc_cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], adc_mosi};
            sck_h     <= sck_sync[SYNC_STAGES-1];
            cs_h      <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sck_s, cs_s, mosi_s, sck_rise, sck_fall, cs_fall;
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_h;
    assign sck_fall = ~sck_s & sck_h;
    assign cs_fall  = ~cs_s & cs_h;

    // Frame state
    state_t            state, state_d;
    logic [1:0]        cfg_cnt, cfg_cnt_d;
    logic [3:0]        bit_cnt, bit_cnt_d;
    logic              sgl_r, sgl_d, odd_r, odd_d;
    logic [DATA_W-1:0] code_r, code_d;
    logic              miso_d, oe_d, done_d, cfg_sgl_d, cfg_odd_d;
    logic [DATA_W-1:0] conv_code_d;
`ifdef MCP3202_LSBF_EN
    logic              msbf_r, msbf_d;
`endif

    // Differential mode subtracts in DATA_W+1 bits. A set top bit means the
    // result is negative, and a negative result reads as zero.
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] sel_code;
    always_comb begin
        diff     = odd_r ? ({1'b0, sample_ch1} - {1'b0, sample_ch0})
                         : ({1'b0, sample_ch0} - {1'b0, sample_ch1});
        sel_code = sgl_r ? (odd_r ? sample_ch1 : sample_ch0)
                         : (diff[DATA_W] ? '0 : diff[DATA_W-1:0]);
    end

    // NOTE: every signal written here gets its default first. A path that
    // leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        state_d     = state;
        cfg_cnt_d   = cfg_cnt;
        bit_cnt_d   = bit_cnt;
        sgl_d       = sgl_r;
        odd_d       = odd_r;
        code_d      = code_r;
        miso_d      = adc_miso;
        oe_d        = miso_oe;
        done_d      = 1'b0;
        cfg_sgl_d   = cfg_sgl;
        cfg_odd_d   = cfg_odd;
        conv_code_d = conv_code;
`ifdef MCP3202_LSBF_EN
        msbf_d      = msbf_r;
`endif
        if (cs_s) begin
            // A deasserted CS overrides any SCK edge detected in the same clk.
            state_d   = IDLE;
            cfg_cnt_d = '0;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
            oe_d      = 1'b0;
        end else begin
            unique case (state)
                IDLE: if (cs_fall) state_d = START;
                START: if (sck_rise && mosi_s) begin
                    state_d   = CFG;
                    cfg_cnt_d = '0;
                end
                CFG: if (sck_rise) begin
                    cfg_cnt_d = cfg_cnt + 2'd1;
                    case (cfg_cnt)
                        2'd0: sgl_d = mosi_s;
                        2'd1: odd_d = mosi_s;
                        default: begin
                            // The MSBF rise freezes the code for the rest of
                            // the frame.
                            code_d    = sel_code;
                            cfg_sgl_d = sgl_r;
                            cfg_odd_d = odd_r;
`ifdef MCP3202_LSBF_EN
                            msbf_d    = mosi_s;
`endif
                            state_d   = NUL;
                        end
                    endcase
                end
                NUL: if (sck_fall) begin
                    oe_d      = 1'b1;
                    miso_d    = 1'b0;
                    bit_cnt_d = 4'(DATA_W - 1);
                    state_d   = MSB;
                end
                MSB: if (sck_fall) begin
                    miso_d = code_r[bit_cnt];
                    if (bit_cnt == 4'd0) begin
                        done_d      = 1'b1;
                        conv_code_d = code_r;
`ifdef MCP3202_LSBF_EN
                        bit_cnt_d   = 4'd1;
                        state_d     = msbf_r ? TAIL : LSB;
`else
                        state_d     = TAIL;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt - 4'd1;
                    end
                end
`ifdef MCP3202_LSBF_EN
                LSB: if (sck_fall) begin
                    miso_d = code_r[bit_cnt];
                    if (bit_cnt == 4'(DATA_W - 1)) state_d = TAIL;
                    else bit_cnt_d = bit_cnt + 4'd1;
                end
`endif
                TAIL: if (sck_fall) miso_d = 1'b0;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cfg_cnt   <= '0;
            bit_cnt   <= '0;
            sgl_r     <= 1'b0;
            odd_r     <= 1'b0;
            code_r    <= '0;
            adc_miso  <= 1'b0;
            miso_oe   <= 1'b0;
            conv_done <= 1'b0;
            conv_code <= '0;
            cfg_sgl   <= 1'b0;
            cfg_odd   <= 1'b0;
`ifdef MCP3202_LSBF_EN
            msbf_r    <= 1'b0;
`endif
        end else begin
            state     <= state_d;
            cfg_cnt   <= cfg_cnt_d;
            bit_cnt   <= bit_cnt_d;
            sgl_r     <= sgl_d;
            odd_r     <= odd_d;
            code_r    <= code_d;
            adc_miso  <= miso_d;
            miso_oe   <= oe_d;
            conv_done <= done_d;
            conv_code <= conv_code_d;
            cfg_sgl   <= cfg_sgl_d;
            cfg_odd   <= cfg_odd_d;
`ifdef MCP3202_LSBF_EN
            msbf_r    <= msbf_d;
`endif
        end
    end

endmodule

// File: tb/tb_mcp3202_spi_responder.sv
// tb_mcp3202_spi_responder
//   Directed frames from an SPI mode (0,0) master model. Before each frame the
//   expected MISO bit stream and the expected conv_done result are queued.
//   One monitor samples MISO on each SCK rise while the output is enabled, and
//   another checks every conv_done pulse against its queue.

module tb_mcp3202_spi_responder;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;   // clk cycles per SCK half period
`ifdef MCP3202_LSBF_EN
    localparam bit LSBF_BUILD  = 1'b1;
`else
    localparam bit LSBF_BUILD  = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] code;
        logic        sgl;
        logic        odd;
    } done_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        adc_clk, adc_cs, adc_mosi;
    logic        adc_miso, miso_oe, conv_done, cfg_sgl, cfg_odd;
    logic [11:0] sample_ch0, sample_ch1, conv_code;

    int    checks = 0;
    int    errors = 0;
    logic  exp_q[$];
    done_t done_q[$];

    always #5 clk = ~clk;

    mcp3202_spi_responder #(.SYNC_STAGES(SYNC_STAGES), .DATA_W(12)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .adc_clk    (adc_clk),
        .adc_cs     (adc_cs),
        .adc_mosi   (adc_mosi),
        .adc_miso   (adc_miso),
        .miso_oe    (miso_oe),
        .sample_ch0 (sample_ch0),
        .sample_ch1 (sample_ch1),
        .conv_done  (conv_done),
        .conv_code  (conv_code),
        .cfg_sgl    (cfg_sgl),
        .cfg_odd    (cfg_odd)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // MISO monitor: the master samples on SCK rise, and the data was driven
    // on the previous fall.
    always @(posedge adc_clk) begin
        if (!adc_cs && miso_oe === 1'b1) begin
            if (exp_q.size() == 0) check("miso_unexpected_bit", 32'd1, 32'd0);
            else check("miso_bit", {31'd0, adc_miso}, {31'd0, exp_q.pop_front()});
        end
    end

    // conv_done monitor
    always @(negedge clk) begin
        if (conv_done === 1'b1) begin
            if (done_q.size() == 0) begin
                check("conv_done_unexpected", 32'd1, 32'd0);
            end else begin
                done_t d;
                d = done_q.pop_front();
                check("conv_code", {20'd0, conv_code}, {20'd0, d.code});
                check("cfg_sgl", {31'd0, cfg_sgl}, {31'd0, d.sgl});
                check("cfg_odd", {31'd0, cfg_odd}, {31'd0, d.odd});
            end
        end
    end

    // Queue the MISO stream seen on the first n data rises, starting with the
    // null bit.
    task automatic push_frame(input logic [11:0] code, input logic sgl, input logic odd,
                              input bit lsbf_tail, input int n, input bit done);
        logic s[$];
        s.push_back(1'b0);
        for (int i = 11; i >= 0; i--) s.push_back(code[i]);
        if (lsbf_tail) for (int i = 1; i < 12; i++) s.push_back(code[i]);
        while (s.size() < n) s.push_back(1'b0);
        for (int i = 0; i < n; i++) exp_q.push_back(s[i]);
        if (done) done_q.push_back('{code: code, sgl: sgl, odd: odd});
    endtask

    task automatic sck_cycle(input logic mosi_v);
        adc_mosi = mosi_v;
        repeat (HALF) @(negedge clk);
        adc_clk = 1'b1;
        repeat (HALF) @(negedge clk);
        adc_clk = 1'b0;
    endtask

    // The samples are inverted after the MSBF rise. The code is already
    // latched at that point, so this change must not reach MISO.
    task automatic start_frame(input int lead, input logic sgl, input logic odd, input logic msbf);
        adc_cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < lead; i++) sck_cycle(1'b0);
        sck_cycle(1'b1);
        sck_cycle(sgl);
        sck_cycle(odd);
        sck_cycle(msbf);
        sample_ch0 = ~sample_ch0;
        sample_ch1 = ~sample_ch1;
    endtask

    task automatic data_rises(input int n);
        for (int i = 0; i < n; i++) sck_cycle(1'b0);
    endtask

    task automatic end_frame();
        repeat (HALF) @(negedge clk);
        adc_cs = 1'b1;
        repeat (SYNC_STAGES + 2) @(negedge clk);
        check("cs_high_oe", {31'd0, miso_oe}, 32'd0);
        check("cs_high_miso", {31'd0, adc_miso}, 32'd0);
        adc_mosi = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        adc_cs     = 1'b0;
        adc_clk    = 1'b0;
        adc_mosi   = 1'b1;
        sample_ch0 = 12'hA5C;
        sample_ch1 = 12'h123;

        // Hold reset while CS is low and SCK toggles.
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sck_cycle(1'b1);
            check("rst_oe", {31'd0, miso_oe}, 32'd0);
            check("rst_miso", {31'd0, adc_miso}, 32'd0);
            check("rst_done", {31'd0, conv_done}, 32'd0);
        end
        check("rst_conv_code", {20'd0, conv_code}, 32'd0);
        check("rst_cfg", {30'd0, cfg_sgl, cfg_odd}, 32'd0);
        reset_n = 1'b1;
        // CS stayed low through reset. Without a fresh fall these clocks must
        // not start a frame.
        for (int i = 0; i < 6; i++) sck_cycle(1'b1);
        check("no_frame_oe", {31'd0, miso_oe}, 32'd0);
        end_frame();

        // SGL=1 ODD=0 MSBF=1 -> ch0
        sample_ch0 = 12'hA5C; sample_ch1 = 12'h123;
        push_frame(12'hA5C, 1'b1, 1'b0, 1'b0, 13, 1'b1);
        start_frame(0, 1'b1, 1'b0, 1'b1);
        data_rises(13);
        end_frame();

        // SGL=1 ODD=1 -> ch1 all ones, then 4 trailing zeros
        sample_ch0 = 12'h000; sample_ch1 = 12'hFFF;
        push_frame(12'hFFF, 1'b1, 1'b1, 1'b0, 17, 1'b1);
        start_frame(0, 1'b1, 1'b1, 1'b1);
        data_rises(17);
        end_frame();

        // Differential ch0-ch1 is negative and clamps to 0.
        sample_ch0 = 12'h100; sample_ch1 = 12'h180;
        push_frame(12'h000, 1'b0, 1'b0, 1'b0, 13, 1'b1);
        start_frame(0, 1'b0, 1'b0, 1'b1);
        data_rises(13);
        end_frame();

        // Differential ch1-ch0 = 0x080
        sample_ch0 = 12'h100; sample_ch1 = 12'h180;
        push_frame(12'h080, 1'b0, 1'b1, 1'b0, 13, 1'b1);
        start_frame(0, 1'b0, 1'b1, 1'b1);
        data_rises(13);
        end_frame();

        // 3 leading zeros, then CS goes high after the null bit and 4 data
        // bits. No conv_done is expected.
        sample_ch0 = 12'hA5C; sample_ch1 = 12'h123;
        push_frame(12'hA5C, 1'b1, 1'b0, 1'b0, 5, 1'b0);
        start_frame(3, 1'b1, 1'b0, 1'b1);
        data_rises(5);
        end_frame();

        // The next frame, with leading zeros, is complete.
        sample_ch0 = 12'hA5C; sample_ch1 = 12'h123;
        push_frame(12'h123, 1'b1, 1'b1, 1'b0, 13, 1'b1);
        start_frame(3, 1'b1, 1'b1, 1'b1);
        data_rises(13);
        end_frame();

        // MSBF=0: LSB-first tail only when that build option is enabled.
        sample_ch0 = 12'h801; sample_ch1 = 12'h000;
        push_frame(12'h801, 1'b1, 1'b0, LSBF_BUILD, 26, 1'b1);
        start_frame(0, 1'b1, 1'b0, 1'b0);
        data_rises(26);
        end_frame();

        // Reset mid-frame drops the output at once.
        sample_ch0 = 12'hA5C; sample_ch1 = 12'h123;
        push_frame(12'hA5C, 1'b1, 1'b0, 1'b0, 3, 1'b0);
        start_frame(0, 1'b1, 1'b0, 1'b1);
        data_rises(3);
        reset_n = 1'b0;
        #1;
        check("midframe_rst_oe", {31'd0, miso_oe}, 32'd0);
        check("midframe_rst_miso", {31'd0, adc_miso}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        data_rises(2);
        end_frame();

        // A fresh frame after the reset.
        sample_ch0 = 12'h3C7; sample_ch1 = 12'h000;
        push_frame(12'h3C7, 1'b1, 1'b0, 1'b0, 13, 1'b1);
        start_frame(0, 1'b1, 1'b0, 1'b1);
        data_rises(13);
        end_frame();

        check("miso_bits_left", exp_q.size(), 32'd0);
        check("conv_done_left", done_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
